// File: rtl/median_linebuf_sram.sv
// Line-pair buffer responder for the median disparity stage: masked writes, 1-cycle
// registered reads with write-through on same-address collision, and a post-reset clear walk.
module median_linebuf_sram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] BWEB,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    output logic              init_done,
    output logic              addr_err,
    output logic              collision
);
    localparam int              MW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [MW-1:0]   LAST    = MW'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [MW-1:0]     clr_cnt_q, clr_cnt_d;
    logic              init_done_q, init_done_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              addr_err_q, addr_err_d;
    logic              collision_q, collision_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [MW-1:0]     mem_wa;
    logic [DATA_W-1:0] mem_wd;

    logic              wr_ok, rd_ok, same;
    logic [DATA_W-1:0] wr_merged;

    assign wr_ok     = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_ok     = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_merged = (D & BWEB) | (mem[wr_addr[MW-1:0]] & ~BWEB);
    assign same      = wr_en && rd_en && wr_ok && rd_ok && (wr_addr == rd_addr);

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        q_d         = q_q;
        addr_err_d  = 1'b0;
        collision_d = 1'b0;
        mem_we      = 1'b0;
        mem_wa      = clr_cnt_q;
        mem_wd      = '0;
        case (state_q)
            CLEAR: begin
                // Clear walk ignores clken so init always completes in DEPTH cycles.
                mem_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (clken) begin
                    if (wr_en && wr_ok) begin
                        mem_we = 1'b1;
                        mem_wa = wr_addr[MW-1:0];
                        mem_wd = wr_merged;
                    end
                    if (rd_en)
                        q_d = !rd_ok ? '0 : (same ? wr_merged : mem[rd_addr[MW-1:0]]);
                    addr_err_d  = (wr_en && !wr_ok) || (rd_en && !rd_ok);
                    collision_d = same;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            q_q         <= '0;
            addr_err_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            q_q         <= q_d;
            addr_err_q  <= addr_err_d;
            collision_q <= collision_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[mem_wa] <= mem_wd;
    end

    assign Q         = q_q;
    assign init_done = init_done_q;
    assign addr_err  = addr_err_q;
    assign collision = collision_q;
endmodule

// File: tb/tb_median_linebuf_sram.sv
// Directed bench for median_linebuf_sram (DEPTH=16) with a word-level reference model.
module tb_median_linebuf_sram;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clken = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [63:0] BWEB = '0, D = '0;
    logic [10:0] wr_addr = '0, rd_addr = '0;
    logic [63:0] Q;
    logic        init_done, addr_err, collision;

    median_linebuf_sram #(.DATA_W(64), .ADDR_W(11), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clken(clken), .wr_en(wr_en), .rd_en(rd_en),
        .BWEB(BWEB), .wr_addr(wr_addr), .rd_addr(rd_addr), .D(D),
        .Q(Q), .init_done(init_done), .addr_err(addr_err), .collision(collision)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: memory as a plain array, clear as a countdown.
    logic [63:0] mm [DEPTH];
    int          m_busy = 0;
    logic [63:0] e_q = '0;
    logic        e_init = 1'b0, e_err = 1'b0, e_col = 1'b0;
    logic        wv, rv;
    logic [63:0] nv;

    function automatic logic [63:0] rdm(int a);
        return (a < DEPTH) ? mm[a[3:0]] : 64'd0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = DEPTH; e_q = '0; e_init = 0; e_err = 0; e_col = 0;
            foreach (mm[i]) mm[i] = '0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) e_init = 1'b1;
            e_err = 0; e_col = 0;
        end else begin
            e_err = 0; e_col = 0;
            if (clken) begin
                wv = wr_en && (int'(wr_addr) < DEPTH);
                rv = rd_en && (int'(rd_addr) < DEPTH);
                nv = (D & BWEB) | (rdm(int'(wr_addr)) & ~BWEB);
                if (rd_en) e_q = !rv ? 64'd0 : ((wv && wr_addr == rd_addr) ? nv : rdm(int'(rd_addr)));
                if (wv) mm[wr_addr[3:0]] = nv;
                e_err = (wr_en && !(int'(wr_addr) < DEPTH)) || (rd_en && !(int'(rd_addr) < DEPTH));
                e_col = wv && rv && (wr_addr == rd_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_Q", Q, e_q);
            chk("model_init_done", {63'd0, init_done}, {63'd0, e_init});
            chk("model_addr_err", {63'd0, addr_err}, {63'd0, e_err});
            chk("model_collision", {63'd0, collision}, {63'd0, e_col});
        end
    end

    task automatic op(input logic ce, input logic we, input logic re, input logic [63:0] bw,
                      input logic [10:0] wa, input logic [10:0] ra, input logic [63:0] d);
        clken = ce; wr_en = we; rd_en = re; BWEB = bw; wr_addr = wa; rd_addr = ra; D = d;
        @(negedge clk);
    endtask

    task automatic wr(input logic [10:0] a, input logic [63:0] d, input logic [63:0] bw);
        op(1, 1, 0, bw, a, 0, d);
    endtask

    task automatic rd(input logic [10:0] a);
        op(1, 0, 1, '0, 0, a, '0);
    endtask

    task automatic wait_init(input string name);
        int k = 0;
        while (!init_done && k < 40) begin
            op(1, 1, 1, '1, 11'(k % 16), 11'(k % 16), 64'hDEAD_BEEF_0BAD_F00D);
            k++;
        end
        chk(name, 64'(k), 64'd16);
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst_Q", Q, 64'd0);
        chk("rst_init_done", {63'd0, init_done}, 64'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        wait_init("clear_len");
        rd(1);  chk("post_clear_rd1", Q, 64'd0);
        rd(9);  chk("post_clear_rd9", Q, 64'd0);

        wr(5, 64'h1111_2222_3333_4444, '1);
        chk("wr_no_q_change", Q, 64'd0);
        rd(5);  chk("rd_latency", Q, 64'h1111_2222_3333_4444);

        wr(7, '1, '1);
        wr(7, '0, 64'hFFFF_FFFF_0000_0000);
        rd(7);  chk("partial_mask", Q, 64'h0000_0000_FFFF_FFFF);

        wr(3, {4{16'hAAAA}}, '1);
        wr(4, 64'h1234_5678_9ABC_DEF0, '1);
        op(1, 1, 1, '1, 3, 3, {4{16'h5555}});
        chk("bypass_Q", Q, {4{16'h5555}});
        chk("bypass_col", {63'd0, collision}, 64'd1);
        op(1, 0, 0, '0, 0, 0, '0);
        chk("col_pulse_end", {63'd0, collision}, 64'd0);
        op(1, 1, 1, '1, 3, 4, {8{8'h0F}});
        chk("diff_addr_Q", Q, 64'h1234_5678_9ABC_DEF0);
        chk("diff_addr_col", {63'd0, collision}, 64'd0);
        op(1, 1, 1, '0, 3, 3, '1);
        chk("bweb0_Q", Q, {8{8'h0F}});
        chk("bweb0_col", {63'd0, collision}, 64'd1);

        rd(5);
        for (int i = 0; i < 3; i++) begin
            op(0, 1, 1, '1, 2, 7, 64'hDEAD_DEAD_DEAD_DEAD);
            chk("stall_hold", Q, 64'h1111_2222_3333_4444);
        end
        rd(2);  chk("stall_no_write", Q, 64'd0);

        wr(20, '1, '1);
        chk("oor_wr_err", {63'd0, addr_err}, 64'd1);
        op(1, 0, 0, '0, 0, 0, '0);
        chk("oor_err_pulse", {63'd0, addr_err}, 64'd0);
        rd(4);  chk("oor_no_alias", Q, 64'h1234_5678_9ABC_DEF0);
        rd(20); chk("oor_rd_Q", Q, 64'd0);
        chk("oor_rd_err", {63'd0, addr_err}, 64'd1);
        op(1, 1, 1, '1, 30, 31, '1);
        chk("oor_both_err", {63'd0, addr_err}, 64'd1);

        rst = 1'b1; op(1, 0, 1, '0, 0, 5, '0); rst = 1'b0;
        chk("rst_drop_init", {63'd0, init_done}, 64'd0);
        for (int i = 0; i < 5; i++) op(1, 1, 0, '1, 11'(i), 0, '1);
        rst = 1'b1; op(1, 0, 0, '0, 0, 0, '0); rst = 1'b0;
        wait_init("clear_len_restart");
        for (int a = 0; a < DEPTH; a++) begin
            rd(11'(a));
            chk("final_clear_rd", Q, 64'd0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/median_linebuf_sram.md
Name: median_linebuf_sram

Overview:
Responder side of the median-filter line-buffer memory interface. It accepts the write/read requests that the median disparity stage issues: packed data word, write/read enables, per-bit write mask, and write/read addresses. It stores one line-pair of packed L/R disparities and returns read data with fixed one-cycle latency. It sits between the median stage and the physical SRAM macro, and serves both as the synthesizable behavioural memory and as the bench responder.

Parameters:
DATA_W, 64, packed word width: {disp_L, disp_R, delayed line pair}, 4 x 16 bits
ADDR_W, 11, address width; covers line widths up to 2047
DEPTH, 2048, number of words; addresses >= DEPTH are out of range

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
clken  in  1  global pipeline enable; 0 = stall
wr_en  in  1  write request, active-high
rd_en  in  1  read request, active-high
BWEB  in  DATA_W  per-bit write mask; 1 = bit written, 0 = bit keeps old value
wr_addr  in  ADDR_W  write address
rd_addr  in  ADDR_W  read address
D  in  DATA_W  write data
Q  out  DATA_W  registered read data
init_done  out  1  high once the post-reset clear has completed
addr_err  out  1  one-cycle pulse: the previous enabled access used an out-of-range address
collision  out  1  one-cycle pulse: the previous cycle had a same-address read and write

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst.
- Reset values: Q=0, init_done=0, addr_err=0, collision=0, state=CLEAR, clear counter=0. Memory contents are not reset directly; the CLEAR walk zeroes them.
- States:
  - CLEAR: writes 0 to address clr_cnt every cycle, independent of clken. clr_cnt increments by 1.
  - CLEAR -> RUN: on the cycle clr_cnt==DEPTH-1 is written. init_done goes 1 the next cycle.
  - CLEAR duration is exactly DEPTH cycles.
  - While in CLEAR: wr_en and rd_en are ignored, Q stays 0, no addr_err or collision pulses.
  - RUN: normal operation. Leaves RUN only via rst.
- rst asserted mid-CLEAR or mid-RUN: next cycle state=CLEAR, clr_cnt=0, init_done=0. The clear restarts from address 0.
- RUN, clken=0: no writes, no reads, Q holds its value, addr_err and collision are 0 the next cycle.
- RUN, clken=1 write: if wr_en and wr_addr<DEPTH, mem[wr_addr] <= (D & BWEB) | (mem[wr_addr] & ~BWEB).
- RUN, clken=1 read: if rd_en and rd_addr<DEPTH, Q <= mem[rd_addr] next cycle. Read latency is exactly 1 enabled cycle.
- rd_en=0 with clken=1: Q holds.
- Read-during-write, same address (both enabled, in range, rd_addr==wr_addr): Q returns the post-write value, (D & BWEB) | (old & ~BWEB), i.e. write-through bypass. collision pulses high the next cycle.
- Different addresses: the read returns the old contents of rd_addr. No collision pulse.
- Out-of-range access, addr >= DEPTH (reachable only if DEPTH < 2^ADDR_W):
  - write: dropped, memory unchanged.
  - read: Q <= 0.
  - addr_err pulses high the next cycle. It pulses once even if both the read and the write are bad.
- BWEB all zero with wr_en=1: no bits change. Not an error; still counts for collision.
- Outputs change only on rising clk edges. No combinational path from inputs to Q, addr_err or collision.

Test Plan:
- Reset/clear: DEPTH=16, pulse rst 1 cycle -> init_done=0 for exactly 16 cycles then 1. A following read of any address returns Q=0. Stimulus sent during CLEAR has no effect.
- Write/read latency: write D=0x1111_2222_3333_4444 to addr 5 with BWEB=all 1, then read addr 5 with clken=1 -> Q=0x1111_2222_3333_4444 exactly one cycle after the read request.
- Partial mask: mem[7]=0xFFFF_FFFF_FFFF_FFFF, write D=0 with BWEB=0xFFFF_FFFF_0000_0000 -> a read returns 0x0000_0000_FFFF_FFFF.
- Collision bypass: mem[3]=0xAAAA..., same-cycle write of 0x5555... and read of addr 3 -> Q=0x5555... next cycle, collision=1 for one cycle. Repeating with rd_addr=4 -> old mem[4] returned, collision=0.
- Stall: a read is issued, then clken=0 for 3 cycles with wr_en=1 to addr 2 -> Q holds, mem[2] unchanged. A read after clken returns gives the old value.
- Out of range with reset mid-run: DEPTH=16, write addr 20 -> addr_err=1 for one cycle, no memory change, a read of addr 20 gives Q=0. Asserting rst mid-stream -> init_done drops, 16-cycle clear repeats, all locations read 0 afterwards.
